// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: access-size encodings, the bridge FSM state
// type and the byte-lane helpers (store byte enables, store data replication, load extraction
// and extension).
package dmem_pkg;

  // cpu_sel encodings
  localparam logic [1:0] SEL_WORD = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_BYTE = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAcc,
    StDone,
    StErr
  } state_e;

  // Byte-lane write enables for an aligned access of the given size at the given lane.
  function automatic logic [3:0] byte_en(input logic [1:0] sel, input logic [1:0] lane);
    logic [3:0] be;
    case (sel)
      SEL_WORD: be = 4'b1111;
      SEL_HALF: be = 4'b0011 << lane;
      SEL_BYTE: be = 4'b0001 << lane;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data copied onto every lane it could land on; byte enables pick one.
  function automatic logic [31:0] replicate_wdata(input logic [1:0] sel,
                                                  input logic [31:0] wdata);
    logic [31:0] rep;
    case (sel)
      SEL_HALF: rep = {2{wdata[15:0]}};
      SEL_BYTE: rep = {4{wdata[7:0]}};
      default:  rep = wdata;
    endcase
    return rep;
  endfunction

  // Pull the addressed lane(s) down to bit 0 and zero- or sign-extend.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] sel,
                                              input logic [1:0] lane, input logic sext);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (sel)
      SEL_WORD: res = word;
      SEL_HALF: res = {{16{sext & sh[15]}}, sh[15:0]};
      SEL_BYTE: res = {{24{sext & sh[7]}}, sh[7:0]};
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// CPU data-port bundle between the core (master) and the memory bridge (slave).
//   req/we/sel/sext/addr/wdata : request fields, driven by the master
//   rdata/ready/err            : completion fields, driven by the slave
interface dmem_bridge_if;
  logic        req;
  logic        we;
  logic [1:0]  sel;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output req, we, sel, sext, addr, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  req, we, sel, sext, addr, wdata,
    output rdata, ready, err
  );
endinterface

// File: rtl/dmem_bytelane_ram.sv
// DEPTH x 32 single-port RAM with per-byte write enables. Write and read are both synchronous;
// rdata_o holds the last read word until the next read. Contents are not reset.
//   clk_i   : clock
//   we_i    : write strobe, be_i selects the lanes written
//   re_i    : read strobe, loads rdata_o on the edge
//   addr_i  : word index
//   wdata_i : write data (already lane-steered)
//   rdata_o : registered read data
module dmem_bytelane_ram #(
  parameter int unsigned DEPTH = 2048
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge between the CPU data port and an internal byte-enabled RAM. Translates
// byte addresses relative to BASE_ADDR into word indices, rejects misaligned, reserved-size and
// out-of-range accesses, inserts WAIT_CYCLES wait states, and steers/extends load data.
//   clk_in : clock, rising edge
//   reset  : asynchronous reset, active-high
//   cpu    : CPU data port (slave side); ready pulses one cycle per access, err qualifies it
module dmem_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  dmem_bridge_if.slave cpu
);
  import dmem_pkg::*;

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      sel_q, sel_d;
  logic            sext_q, sext_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            ld_valid_q, ld_valid_d;

  logic [31:0]     off;
  logic            in_range;
  logic            req_err;
  logic            accept;
  state_e          accept_state;

  logic            ready;
  logic            err;
  logic            ram_we;
  logic            ram_re;
  logic [31:0]     ram_rdata;

  // Address translation and request checking on the live CPU inputs.
  assign off      = cpu.addr - BASE_ADDR;  // addresses below the base wrap to a huge offset
  assign in_range = off < SPAN;
  assign req_err  = !in_range || (cpu.sel == SEL_RSVD) ||
                    ((cpu.sel == SEL_WORD) && (off[1:0] != 2'b00)) ||
                    ((cpu.sel == SEL_HALF) && off[0]);

  assign accept       = cpu.req &&
                        ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign accept_state = req_err ? StErr : ((WAIT_CYCLES == 0) ? StAcc : StWait);

  // State register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= SEL_WORD;
      sext_q     <= 1'b0;
      idx_q      <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ld_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      sext_q     <= sext_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ld_valid_q <= ld_valid_d;
    end
  end

  // Next state and capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    sel_d      = sel_q;
    sext_d     = sext_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    ld_valid_d = ld_valid_q;

    unique case (state_q)
      StIdle: begin
        if (cpu.req) state_d = accept_state;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StAcc;
      end
      StAcc: begin
        state_d = StDone;
        if (!we_q) ld_valid_d = 1'b1;  // RAM output register now holds the load word
      end
      StDone, StErr: begin
        state_d = cpu.req ? accept_state : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      cnt_d      = WAIT_INIT;
      we_d       = cpu.we;
      sel_d      = cpu.sel;
      sext_d     = cpu.sext;
      idx_d      = off[AW+1:2];
      lane_d     = off[1:0];
      wdata_d    = replicate_wdata(cpu.sel, cpu.wdata);
      be_d       = byte_en(cpu.sel, off[1:0]);
      ld_valid_d = 1'b0;
    end
  end

  // Outputs: RAM is touched only in StAcc, which an errored access never reaches.
  always_comb begin
    ready  = 1'b0;
    err    = 1'b0;
    ram_we = 1'b0;
    ram_re = 1'b0;
    unique case (state_q)
      StAcc: begin
        ram_we = we_q;
        ram_re = !we_q;
      end
      StDone: ready = 1'b1;
      StErr: begin
        ready = 1'b1;
        err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu.ready = ready;
  assign cpu.err   = err;
  assign cpu.rdata = ld_valid_q ? extend_load(ram_rdata, sel_q, lane_q, sext_q) : 32'h0;

  dmem_bytelane_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk_in),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .be_i   (be_q),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

endmodule
